// File: rtl/psum_lane_tx.sv
// rtl/psum_lane_tx.sv - three-lane partial-sum transmitter with per-lane FIFOs
//
// Steers a serial lane0/lane1/lane2 partial-sum stream into three FIFOs and
// presents each as an independent valid/ready channel.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_data/in_sof/in_valid/in_ready : serial input word, start-of-frame mark
//   outN_data/outN_valid/outN_ready  : per-lane output channels (N = 0..2)
//   frame_cnt             : completed frames (lane2 word accepted), wrapping
//   sync_err              : sticky flag, sof seen while not at lane0
module psum_lane_tx #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 2,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out0_data,
    output logic [DWIDTH-1:0] out1_data,
    output logic [DWIDTH-1:0] out2_data,
    output logic              out0_valid,
    output logic              out1_valid,
    output logic              out2_valid,
    input  logic              out0_ready,
    input  logic              out1_ready,
    input  logic              out2_ready,
    output logic [CWIDTH-1:0] frame_cnt,
    output logic              sync_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {LANE0 = 2'd0, LANE1 = 2'd1, LANE2 = 2'd2} lane_t;

    lane_t             state_q;
    lane_t             state_d;
    logic [1:0]        eff;
    logic              accept;

    logic [DWIDTH-1:0] mem   [3][DEPTH];
    logic [AW-1:0]     wptr  [3];
    logic [AW-1:0]     rptr  [3];
    logic [AW:0]       count [3];
    logic [2:0]        full;
    logic [2:0]        empty;
    logic [2:0]        push;
    logic [2:0]        pop;
    logic [2:0]        out_ready_v;

    assign out_ready_v = {out2_ready, out1_ready, out0_ready};

    always_comb begin
        for (int l = 0; l < 3; l++) begin
            full[l]  = (count[l] == (AW+1)'(DEPTH));
            empty[l] = (count[l] == '0);
        end
    end

    // sof forces lane0 regardless of where the pointer is (resync path)
    always_comb begin
        eff = in_sof ? 2'd0 : state_q;
    end

    // No pass-through: a full lane blocks input even if it pops this cycle
    assign in_ready = rst_n & ~full[eff];
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int l = 0; l < 3; l++) begin
            push[l] = accept && (eff == 2'(l));
            pop[l]  = ~empty[l] & out_ready_v[l];
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (eff)
                2'd0:    state_d = LANE1;
                2'd1:    state_d = LANE2;
                default: state_d = LANE0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LANE0;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if (!rst_n) begin
                wptr[l]  <= '0;
                rptr[l]  <= '0;
                count[l] <= '0;
            end else begin
                if (push[l]) begin
                    mem[l][wptr[l]] <= in_data;
                    wptr[l]         <= wptr[l] + 1'b1;
                end
                if (pop[l]) begin
                    rptr[l] <= rptr[l] + 1'b1;
                end
                if (push[l] && !pop[l]) begin
                    count[l] <= count[l] + 1'b1;
                end else if (!push[l] && pop[l]) begin
                    count[l] <= count[l] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            sync_err  <= 1'b0;
        end else if (accept) begin
            if (eff == 2'd2) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (in_sof && state_q != LANE0) begin
                sync_err <= 1'b1;
            end
        end
    end

    // Data is forced to zero while a lane is empty so stale words never leak
    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign out2_valid = ~empty[2];
    assign out0_data  = empty[0] ? '0 : mem[0][rptr[0]];
    assign out1_data  = empty[1] ? '0 : mem[1][rptr[1]];
    assign out2_data  = empty[2] ? '0 : mem[2][rptr[2]];

endmodule

// File: tb/tb_psum_lane_tx.sv
// tb/tb_psum_lane_tx.sv - scoreboard bench for psum_lane_tx
module tb_psum_lane_tx;

    localparam int DW = 8;
    localparam int DP = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out0_data, out1_data, out2_data;
    logic          out0_valid, out1_valid, out2_valid;
    logic          out0_ready, out1_ready, out2_ready;
    logic [CW-1:0] frame_cnt;
    logic          sync_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    int            mptr = 0;
    logic [CW-1:0] mfc  = '0;
    logic          merr = 1'b0;

    always #5 clk = ~clk;

    psum_lane_tx #(.DWIDTH(DW), .DEPTH(DP), .CWIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data),
        .out0_valid(out0_valid), .out1_valid(out1_valid), .out2_valid(out2_valid),
        .out0_ready(out0_ready), .out1_ready(out1_ready), .out2_ready(out2_ready),
        .frame_cnt(frame_cnt), .sync_err(sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model is the state after the previous edge; compare, then apply the
    // handshakes that the next edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            int  eff;
            bit  exp_rdy;
            int  sz;
            eff = in_sof ? 0 : mptr;
            sz  = (eff == 0) ? q0.size() : (eff == 1) ? q1.size() : q2.size();
            exp_rdy = rst_n && (sz < DP);
            if (in_valid) check("in_ready", in_ready, exp_rdy);
            check("out0_valid", out0_valid, q0.size() != 0);
            check("out1_valid", out1_valid, q1.size() != 0);
            check("out2_valid", out2_valid, q2.size() != 0);
            if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
            if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
            if (q2.size() != 0) check("out2_data", out2_data, q2[0]);
            check("frame_cnt", frame_cnt, mfc);
            check("sync_err", sync_err, merr);
            if (!rst_n) begin
                q0.delete(); q1.delete(); q2.delete();
                mptr = 0; mfc = '0; merr = 1'b0;
            end else begin
                if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
                if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
                if (q2.size() != 0 && out2_ready) void'(q2.pop_front());
                if (in_valid && exp_rdy) begin
                    if (eff == 0) q0.push_back(in_data);
                    else if (eff == 1) q1.push_back(in_data);
                    else q2.push_back(in_data);
                    if (in_sof && mptr != 0) merr = 1'b1;
                    if (eff == 2) mfc = mfc + 1'b1;
                    mptr = (eff + 1) % 3;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s);
        bit acc = 1'b0;
        in_data  = d;
        in_sof   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        n_checks++;
        assert (acc) n_pass++;
        else $error("FAIL send_timeout observed=0 expected=1 data=%0h", d);
    endtask

    task automatic frame(input logic [DW-1:0] base);
        send(base, 1'b1);
        send(base + 8'd1, 1'b0);
        send(base + 8'd2, 1'b0);
    endtask

    task automatic set_ready(input logic r0, input logic r1, input logic r2);
        out0_ready = r0;
        out1_ready = r1;
        out2_ready = r2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_sof = 1'b0; in_valid = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        step(2);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out0_data", out0_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single frame
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        step(2);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_sync_err", sync_err, 0);

        // back-pressure fill on lane1
        set_ready(1'b1, 1'b0, 1'b1);
        frame(8'h40);
        frame(8'h50);
        send(8'h60, 1'b1);
        in_data = 8'h61; in_sof = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_stall", in_ready, 0);
            @(posedge clk); #1;
        end
        set_ready(1'b1, 1'b1, 1'b1);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        step(4);
        check("t2_frame_cnt", frame_cnt, 4);

        // full lane0 with pop in the same cycle
        set_ready(1'b0, 1'b1, 1'b1);
        frame(8'h70);
        frame(8'h80);
        in_data = 8'h90; in_sof = 1'b1; in_valid = 1'b1;
        out0_ready = 1'b1;
        @(negedge clk);
        check("t3_no_passthru", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_next_cycle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        send(8'h91, 1'b0);
        send(8'h92, 1'b0);
        step(4);
        check("t3_frame_cnt", frame_cnt, 7);

        // resync
        send(8'hA0, 1'b1);
        send(8'hB0, 1'b0);
        send(8'hC0, 1'b1);
        step(3);
        check("t4_sync_err", sync_err, 1);
        check("t4_frame_cnt", frame_cnt, 7);
        check("t4_out2_empty", out2_valid, 0);
        send(8'hD0, 1'b0);
        send(8'hE0, 1'b0);
        step(3);
        check("t4_frame_done", frame_cnt, 8);

        // counter wrap
        do_reset();
        check("t5_rst_cnt", frame_cnt, 0);
        check("t5_rst_err", sync_err, 0);
        for (int f = 1; f <= 17; f++) begin
            frame(8'(f * 3));
            if (f == 15) check("t5_cnt15", frame_cnt, 15);
            if (f == 16) check("t5_cnt16", frame_cnt, 0);
            if (f == 17) check("t5_cnt17", frame_cnt, 1);
        end
        step(3);

        // mid-frame reset
        set_ready(1'b0, 1'b0, 1'b0);
        send(8'hF1, 1'b1);
        send(8'hF2, 1'b0);
        do_reset();
        check("t6_v0", out0_valid, 0);
        check("t6_v1", out1_valid, 0);
        check("t6_v2", out2_valid, 0);
        check("t6_cnt", frame_cnt, 0);
        check("t6_err", sync_err, 0);
        set_ready(1'b1, 1'b1, 1'b1);
        send(8'h5A, 1'b0);
        @(negedge clk);
        check("t6_lane0_data", out0_data, 8'h5A);
        @(posedge clk); #1;
        send(8'h5B, 1'b0);
        send(8'h5C, 1'b0);
        step(3);
        check("t6_frame_cnt", frame_cnt, 1);
        check("t6_sync_err", sync_err, 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_lane_tx.md
Name: psum_lane_tx

Overview:
- Transmit side of the three-lane partial-sum channel that feeds the psum adder.
- Accepts a serial stream of partial sums from the PE-row collector, ordered lane0, lane1, lane2, lane0, and so on.
- Steers each word into a per-lane FIFO.
- Presents three independent valid/ready output channels, so the adder's three-way join can complete regardless of per-lane back-pressure.

Parameters:
- DWIDTH, 8: width of each partial-sum word.
- DEPTH, 2: entries per lane FIFO. Power of 2, minimum 2.
- CWIDTH, 16: width of the frame counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  DWIDTH  partial-sum word from the collector.
- in_sof  input  1  marks the word as lane0 (start of frame).
- in_valid  input  1  in_data/in_sof are valid.
- in_ready  output  1  block accepts the word this cycle.
- out0_data, out1_data, out2_data  output  DWIDTH  head of the lane 0/1/2 FIFO.
- out0_valid, out1_valid, out2_valid  output  1  lane FIFO non-empty.
- out0_ready, out1_ready, out2_ready  input  1  adder side takes the head word.
- frame_cnt  output  CWIDTH  number of completed frames (a frame completes when its lane2 word is accepted).
- sync_err  output  1  sticky framing-error flag.

Behaviour:
- **Reset** (rst_n=0 at a rising edge):
  - lane pointer = LANE0; all FIFOs empty.
  - outN_valid=0, outN_data=0, frame_cnt=0, sync_err=0.
  - in_ready=0 while rst_n=0.
  - Reset asserted mid-frame discards all buffered words and the partial frame; no output survives it.
- **Lane-pointer FSM**: states LANE0 -> LANE1 -> LANE2 -> LANE0. Advances only on an accepted input word (in_valid & in_ready).
- **Effective lane**: eff = 0 if in_sof=1, else the current pointer.
- **in_ready** = ~full[eff], purely combinational from FIFO state and in_sof.
  - No pass-through: a full FIFO blocks input even if the same lane pops in that cycle.
- **Accept**: word is written into FIFO[eff] at the edge. Pointer next = (eff+1) mod 3.
- **Latency**: a word accepted at edge k is visible on outN_data with outN_valid=1 after edge k, i.e. one cycle, when its FIFO was empty.
- **Outputs**:
  - outN_valid = ~empty[N]; outN_data = FIFO[N] head.
  - Pop on outN_valid & outN_ready.
  - Lanes are fully independent; any combination of the three may pop in the same cycle.
- **Simultaneous push and pop** on the same non-full, non-empty lane: both take effect and occupancy is unchanged.
  - On an empty lane, the pushed word appears next cycle; there is no same-cycle bypass.
- **Wrap-around**: FIFO read/write pointers wrap modulo DEPTH. Occupancy counters range 0..DEPTH.
- **frame_cnt**: +1 on each accepted word with eff=2. Wraps from 2^CWIDTH-1 to 0.
- **Resync**: an accepted word with in_sof=1 while the pointer != LANE0:
  - sets sync_err=1 (sticky until reset);
  - goes to lane 0; pointer becomes LANE1;
  - already-buffered words of the aborted frame remain queued and are still delivered;
  - frame_cnt is not incremented for the aborted frame.
- in_sof=0 while the pointer is at LANE0 is legal and raises no error.
- in_valid=0: no state change on the input side.
- in_data is not examined arithmetically; the word is stored and forwarded bit-exact.

Test Plan:
1. **Single frame**:
   - Stimulus: after reset, send 8'h11(sof), 8'h22, 8'h33 back-to-back with all outN_ready=1.
   - Required: out0/1/2 present 11/22/33, each 1 cycle after its accept; frame_cnt=1; sync_err=0.
2. **Back-pressure fill**:
   - Stimulus: hold out1_ready=0, DEPTH=2, stream 3 frames (sof on each lane0 word).
   - Required: in_ready drops when the 3rd lane1 word is offered; the stream stalls.
   - Release out1_ready: lane1 delivers words in order, and the stalled frame then completes; frame_cnt=3.
3. **Full-lane pop in same cycle**:
   - Stimulus: lane0 full and pointer at LANE0, assert out0_ready and in_valid together.
   - Required: in_ready=0 that cycle (no pass-through); the word is accepted the following cycle.
4. **Resync**:
   - Stimulus: send A(sof), B, then C(sof).
   - Required: sync_err=1; out0 delivers A then C; out1 delivers B; nothing on out2; frame_cnt=0; the next two words go to lanes 1 and 2, giving frame_cnt=1.
5. **Counter wrap**:
   - Stimulus: CWIDTH=4, 17 complete frames.
   - Required: frame_cnt reads 15 after frame 15, 0 after frame 16, 1 after frame 17.
6. **Mid-frame reset**:
   - Stimulus: after accepting lane0 and lane1 words with outputs stalled, pull rst_n low for one edge.
   - Required: all outN_valid=0, frame_cnt=0, sync_err=0, pointer at LANE0; a new frame then delivers normally.
